// File: rtl/fp_add_pipe_if.sv
// rtl/fp_add_pipe_if.sv - operand/result stream bundle for fp_add_pipe
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int XLEN = EXP_W + MAN_W + 1;

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic             op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             overflow;
  logic             underflow;
  logic             invalid;

  modport master (
    output in_valid, a, b, op, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, a, b, op, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - three-stage IEEE-754 add/sub with RNE rounding and tag passthrough
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = EXP_W + MAN_W + 1,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fp_add_pipe_if.slave bus
);
  localparam int FW  = MAN_W + 4;
  localparam int LZW = $clog2(FW + 1);
  localparam int EW2 = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] SH_MAX   = EXP_W'(MAN_W + 3);
  localparam logic [XLEN-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic             s1_v_d, s1_v_q, s1_spec_d, s1_spec_q, s1_inv_d, s1_inv_q;
  logic             s1_sign_d, s1_sign_q, s1_sub_d, s1_sub_q;
  logic [TAG_W-1:0] s1_tag_d, s1_tag_q;
  logic [XLEN-1:0]  s1_spec_res_d, s1_spec_res_q;
  logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
  logic [FW-1:0]    s1_big_d, s1_big_q, s1_small_d, s1_small_q;

  logic             s2_v_d, s2_v_q, s2_spec_d, s2_spec_q, s2_inv_d, s2_inv_q;
  logic             s2_sign_d, s2_sign_q;
  logic [TAG_W-1:0] s2_tag_d, s2_tag_q;
  logic [XLEN-1:0]  s2_spec_res_d, s2_spec_res_q;
  logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
  logic [FW:0]      s2_sum_d, s2_sum_q;
  logic [LZW-1:0]   s2_lzc_d, s2_lzc_q;

  logic             s3_v_d, s3_v_q, s3_ovf_d, s3_ovf_q, s3_unf_d, s3_unf_q, s3_inv_d, s3_inv_q;
  logic [TAG_W-1:0] s3_tag_d, s3_tag_q;
  logic [XLEN-1:0]  s3_res_d, s3_res_q;

  logic en;
  assign en = !s3_v_q || bus.out_ready;

  logic             sa, sb, za, zb, infa, infb, nana, nanb, a_big, nan_in;
  logic [EXP_W-1:0] ea, eb, big_e, sml_e, shamt;
  logic [MAN_W-1:0] ma_z, mb_z;
  logic [MAN_W:0]   big_m, sml_m;
  logic [2*FW-1:0]  wide;

  always_comb begin
    sa    = bus.a[XLEN-1];
    sb    = bus.b[XLEN-1] ^ bus.op;
    ea    = bus.a[XLEN-2:MAN_W];
    eb    = bus.b[XLEN-2:MAN_W];
    za    = (ea == '0);
    zb    = (eb == '0);
    ma_z  = za ? '0 : bus.a[MAN_W-1:0];
    mb_z  = zb ? '0 : bus.b[MAN_W-1:0];
    infa  = (ea == EXP_ONES) && (bus.a[MAN_W-1:0] == '0);
    infb  = (eb == EXP_ONES) && (bus.b[MAN_W-1:0] == '0);
    nana  = (ea == EXP_ONES) && (bus.a[MAN_W-1:0] != '0);
    nanb  = (eb == EXP_ONES) && (bus.b[MAN_W-1:0] != '0);
    a_big = {ea, ma_z} >= {eb, mb_z};
    big_e = a_big ? ea : eb;
    sml_e = a_big ? eb : ea;
    big_m = a_big ? {!za, ma_z} : {!zb, mb_z};
    sml_m = a_big ? {!zb, mb_z} : {!za, ma_z};
    shamt = big_e - sml_e;
    // Bits shifted past the field land in the low half and collapse into sticky.
    wide   = {sml_m, 3'b000, {FW{1'b0}}} >> shamt;
    nan_in = nana || nanb || (infa && infb && (sa != sb));

    s1_v_d        = s1_v_q;
    s1_tag_d      = s1_tag_q;
    s1_spec_d     = s1_spec_q;
    s1_inv_d      = s1_inv_q;
    s1_spec_res_d = s1_spec_res_q;
    s1_sign_d     = s1_sign_q;
    s1_exp_d      = s1_exp_q;
    s1_big_d      = s1_big_q;
    s1_small_d    = s1_small_q;
    s1_sub_d      = s1_sub_q;
    if (en) begin
      s1_v_d    = bus.in_valid;
      s1_tag_d  = bus.in_tag;
      s1_spec_d = nan_in || infa || infb || (za && zb);
      s1_inv_d  = nan_in;
      if (nan_in)    s1_spec_res_d = QNAN;
      else if (infa) s1_spec_res_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
      else if (infb) s1_spec_res_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
      else           s1_spec_res_d = {sa && sb, {(XLEN-1){1'b0}}};
      s1_sign_d  = a_big ? sa : sb;
      s1_exp_d   = big_e;
      s1_big_d   = {big_m, 3'b000};
      s1_small_d = (shamt >= SH_MAX) ? {{(FW-1){1'b0}}, |sml_m}
                 : (wide[2*FW-1:FW] | {{(FW-1){1'b0}}, |wide[FW-1:0]});
      s1_sub_d   = sa ^ sb;
    end
  end

  logic [FW:0]    sum_c;
  logic [LZW-1:0] lzc_c;

  always_comb begin
    sum_c = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                     : ({1'b0, s1_big_q} + {1'b0, s1_small_q});
    lzc_c = LZW'(FW);
    for (int i = 0; i < FW; i++) begin
      if (sum_c[i]) lzc_c = LZW'(FW - 1 - i);
    end

    s2_v_d        = s2_v_q;
    s2_tag_d      = s2_tag_q;
    s2_spec_d     = s2_spec_q;
    s2_inv_d      = s2_inv_q;
    s2_spec_res_d = s2_spec_res_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_sum_d      = s2_sum_q;
    s2_lzc_d      = s2_lzc_q;
    if (en) begin
      s2_v_d        = s1_v_q;
      s2_tag_d      = s1_tag_q;
      s2_spec_d     = s1_spec_q;
      s2_inv_d      = s1_inv_q;
      s2_spec_res_d = s1_spec_res_q;
      s2_sign_d     = s1_sign_q;
      s2_exp_d      = s1_exp_q;
      s2_sum_d      = sum_c;
      s2_lzc_d      = lzc_c;
    end
  end

  logic [FW-1:0]    norm;
  logic [EW2-1:0]   exp_n, exp_r;
  logic             rnd;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] man_r;
  logic [XLEN-1:0]  res_c;
  logic             ovf_c, unf_c, inv_c;

  always_comb begin
    if (s2_sum_q[FW]) begin
      norm  = {s2_sum_q[FW:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = {2'b00, s2_exp_q} + EW2'(1);
    end else begin
      norm  = s2_sum_q[FW-1:0] << s2_lzc_q;
      exp_n = {2'b00, s2_exp_q} - EW2'(s2_lzc_q);
    end
    rnd = norm[2] && (norm[1] || norm[0] || norm[3]);
    mr  = {1'b0, norm[FW-1:3]} + {{(MAN_W+1){1'b0}}, rnd};
    if (mr[MAN_W+1]) begin
      exp_r = exp_n + EW2'(1);
      man_r = mr[MAN_W:1];
    end else begin
      exp_r = exp_n;
      man_r = mr[MAN_W-1:0];
    end

    res_c = {s2_sign_q, exp_r[EXP_W-1:0], man_r};
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inv_c = 1'b0;
    if (s2_spec_q) begin
      res_c = s2_spec_res_q;
      inv_c = s2_inv_q;
    end else if (s2_sum_q == '0) begin
      res_c = '0;
    end else if (!exp_r[EW2-1] && (exp_r >= {2'b00, EXP_ONES})) begin
      res_c = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
    end else if (exp_r[EW2-1] || (exp_r == '0)) begin
      res_c = {s2_sign_q, {(XLEN-1){1'b0}}};
      unf_c = 1'b1;
    end

    s3_v_d   = s3_v_q;
    s3_tag_d = s3_tag_q;
    s3_res_d = s3_res_q;
    s3_ovf_d = s3_ovf_q;
    s3_unf_d = s3_unf_q;
    s3_inv_d = s3_inv_q;
    if (en) begin
      s3_v_d   = s2_v_q;
      s3_tag_d = s2_tag_q;
      s3_res_d = res_c;
      s3_ovf_d = ovf_c;
      s3_unf_d = unf_c;
      s3_inv_d = inv_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0; s1_tag_q <= '0; s1_spec_q <= 1'b0; s1_inv_q <= 1'b0;
      s1_spec_res_q <= '0; s1_sign_q <= 1'b0; s1_exp_q <= '0;
      s1_big_q <= '0; s1_small_q <= '0; s1_sub_q <= 1'b0;
      s2_v_q <= 1'b0; s2_tag_q <= '0; s2_spec_q <= 1'b0; s2_inv_q <= 1'b0;
      s2_spec_res_q <= '0; s2_sign_q <= 1'b0; s2_exp_q <= '0;
      s2_sum_q <= '0; s2_lzc_q <= '0;
      s3_v_q <= 1'b0; s3_tag_q <= '0; s3_res_q <= '0;
      s3_ovf_q <= 1'b0; s3_unf_q <= 1'b0; s3_inv_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d; s1_tag_q <= s1_tag_d; s1_spec_q <= s1_spec_d; s1_inv_q <= s1_inv_d;
      s1_spec_res_q <= s1_spec_res_d; s1_sign_q <= s1_sign_d; s1_exp_q <= s1_exp_d;
      s1_big_q <= s1_big_d; s1_small_q <= s1_small_d; s1_sub_q <= s1_sub_d;
      s2_v_q <= s2_v_d; s2_tag_q <= s2_tag_d; s2_spec_q <= s2_spec_d; s2_inv_q <= s2_inv_d;
      s2_spec_res_q <= s2_spec_res_d; s2_sign_q <= s2_sign_d; s2_exp_q <= s2_exp_d;
      s2_sum_q <= s2_sum_d; s2_lzc_q <= s2_lzc_d;
      s3_v_q <= s3_v_d; s3_tag_q <= s3_tag_d; s3_res_q <= s3_res_d;
      s3_ovf_q <= s3_ovf_d; s3_unf_q <= s3_unf_d; s3_inv_q <= s3_inv_d;
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = s3_v_q;
  assign bus.result    = s3_res_q;
  assign bus.out_tag   = s3_tag_q;
  assign bus.overflow  = s3_ovf_q;
  assign bus.underflow = s3_unf_q;
  assign bus.invalid   = s3_inv_q;
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - directed and backpressure checks of fp_add_pipe against a result scoreboard
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();
  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [2:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  exp_t got;
  exp_t held;
  logic held_v = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   lat;

  logic [31:0] st_a [8] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h3F800000, 32'h40800000, 32'hBF800000, 32'h3F000000};
  logic [31:0] st_b [8] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000,
                            32'h40000000, 32'h40800000, 32'hBF800000, 32'h3F000000};
  logic        st_op[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] st_r [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40000000,
                            32'hBF800000, 32'h41000000, 32'hC0000000, 32'h3F800000};

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Pushes on acceptance, pops on consumption; both decided at the negedge before the capturing edge.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", {bus.result, bus.out_tag, bus.overflow, bus.underflow, bus.invalid}, held);
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = {bus.result, bus.out_tag, bus.overflow, bus.underflow, bus.invalid};
      if (bus.in_valid && bus.in_ready) sb_q.push_back(cur);
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          got = sb_q.pop_front();
          check("result", bus.result, got.res);
          check("out_tag", bus.out_tag, got.tag);
          check("flags_ovf_unf_inv", {bus.overflow, bus.underflow, bus.invalid}, got.flg);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [3:0] tag, input logic [31:0] res, input logic [2:0] flg,
                      input bit rnd);
    int   c = 0;
    logic acc = 1'b0;
    bus.a = a; bus.b = b; bus.op = op; bus.in_tag = tag;
    cur = {res, tag, flg};
    bus.in_valid = 1'b1;
    do begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      c++;
    end while (!acc && c < 50);
    bus.in_valid = 1'b0;
    check("accept", acc, 1);
  endtask

  task automatic drain(input bit rnd);
    int c = 0;
    while (sb_q.size() != 0 && c < 200) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      c++;
    end
    bus.out_ready = 1'b1;
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    cur = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_flags", {bus.overflow, bus.underflow, bus.invalid}, 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", bus.in_ready, 1);

    // 1 + 2 with latency measured from the accepting edge
    bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0; bus.in_tag = 4'd5;
    cur = {32'h40400000, 4'd5, 3'b000};
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("accept_lat", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
    drain(1'b0);

    send(32'h3F800000, 32'h3F800000, 1'b1, 4'd1, 32'h00000000, 3'b000, 1'b0);
    send(32'h80000000, 32'h80000000, 1'b0, 4'd2, 32'h80000000, 3'b000, 1'b0);
    send(32'h3F800000, 32'h33800000, 1'b0, 4'd3, 32'h3F800000, 3'b000, 1'b0);
    send(32'h3F800000, 32'h33C00000, 1'b0, 4'd4, 32'h3F800001, 3'b000, 1'b0);
    send(32'h3F800001, 32'h33800000, 1'b0, 4'd5, 32'h3F800002, 3'b000, 1'b0);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd6, 32'h7F800000, 3'b100, 1'b0);
    send(32'h7F800000, 32'h7F800000, 1'b1, 4'd7, 32'h7FC00000, 3'b001, 1'b0);
    send(32'h00800001, 32'h00800000, 1'b1, 4'd8, 32'h00000000, 3'b010, 1'b0);
    send(32'h7F800000, 32'h3F800000, 1'b0, 4'd9, 32'h7F800000, 3'b000, 1'b0);
    drain(1'b0);

    for (int i = 0; i < 8; i++) begin
      send(st_a[i], st_b[i], st_op[i], 4'(i), st_r[i], 3'b000, 1'b1);
    end
    bus.out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("stall_out_valid", bus.out_valid, 1);
    check("stall_in_ready", bus.in_ready, 0);
    drain(1'b1);

    // Reset with three operations in flight and the output stalled
    bus.out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'd9, 32'h40000000, 3'b000, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'd10, 32'h40000000, 3'b000, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'd11, 32'h40000000, 3'b000, 1'b0);
    check("pre_reset_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_drops_valid", bus.out_valid, 0);
    check("reset_clears_result", bus.result, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("in_ready_after_midreset", bus.in_ready, 1);
    send(32'h3F800000, 32'h3F800000, 1'b0, 4'd3, 32'h40000000, 3'b000, 1'b0);
    drain(1'b0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("no_stale", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
